// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters, sync generation and two-stage video output pipeline
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clck,
    input  logic       rst,
    input  logic       pixel,
    output logic [9:0] vgax,
    output logic [8:0] vgay,
    output logic       update,
    output logic       hsync,
    output logic       vsync,
    output logic       video
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       active;
    logic       hs_n;
    logic       vs_n;
    logic       active_d1;
    logic       hs_n_d1;
    logic       vs_n_d1;

    assign vgax = hcnt;
    assign vgay = vcnt[8:0];

    // Stage-0 decode straight off the counters.
    always_comb begin
        active = (hcnt < H_VIS) && (vcnt < V_VIS);
        hs_n   = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
        vs_n   = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
    end

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            active_d1 <= 1'b0;
            hs_n_d1   <= 1'b1;
            vs_n_d1   <= 1'b1;
            video     <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            update    <= 1'b0;
        end else begin
            if (hcnt == H_MAX) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_MAX) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
            active_d1 <= active;
            hs_n_d1   <= hs_n;
            vs_n_d1   <= vs_n;
            video     <= pixel & active_d1;
            hsync     <= hs_n_d1;
            vsync     <= vs_n_d1;
            // Look one position ahead so the strobe coincides with counters at (0, V_VISIBLE).
            update    <= (hcnt == H_MAX) && (vcnt == V_VIS_LAST);
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - randomized self-checking bench for vga_timing against a positional reference model
module tb_vga_timing;

    localparam int HV = 20, HF = 4, HS = 6, HB = 5;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int TX = 10, TY = 5;

    logic       clck;
    logic       rst;
    logic       pixel;
    logic [9:0] vgax;
    logic [8:0] vgay;
    logic       update;
    logic       hsync;
    logic       vsync;
    logic       video;

    int tests = 0;
    int fails = 0;
    int n;
    int mode;
    logic pix [0:8191];

    int upd_cnt, vid_cnt, hs_cnt, vs_cnt, last_upd;
    bit found;

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clck(clck), .rst(rst), .pixel(pixel),
        .vgax(vgax), .vgay(vgay), .update(update),
        .hsync(hsync), .vsync(vsync), .video(video)
    );

    initial clck = 1'b0;
    always #5 clck = ~clck;

    // Position reached after k clock edges from (0,0).
    function automatic int px(int k);
        return k % HT;
    endfunction
    function automatic int py(int k);
        return (k / HT) % VT;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vgax"}, int'(vgax), 0);
        check({tag, "_vgay"}, int'(vgay), 0);
        check({tag, "_hsync"}, int'(hsync), 1);
        check({tag, "_vsync"}, int'(vsync), 1);
        check({tag, "_video"}, int'(video), 0);
        check({tag, "_update"}, int'(update), 0);
    endtask

    task automatic drive_pixel();
        case (mode)
            0:       pixel = 1'($urandom_range(0, 1));
            1:       pixel = 1'b1;
            default: pixel = (n >= 1) && (px(n - 1) == TX) && (py(n - 1) == TY);
        endcase
        pix[n] = pixel;
    endtask

    // Advance one edge, compare every output with the model, then drive the next pixel.
    task automatic step();
        int p;
        logic e_hs, e_vs, e_vid, e_upd;
        @(posedge clck);
        #1;
        n++;
        e_upd = (px(n) == 0) && (py(n) == VV);
        if (n >= 2) begin
            p = n - 2;
            e_hs  = !(px(p) >= HV + HF && px(p) < HV + HF + HS);
            e_vs  = !(py(p) >= VV + VF && py(p) < VV + VF + VS);
            e_vid = pix[n - 1] && (px(p) < HV) && (py(p) < VV);
        end else begin
            e_hs = 1'b1; e_vs = 1'b1; e_vid = 1'b0;
        end
        check("vgax", int'(vgax), px(n));
        check("vgay", int'(vgay), py(n));
        check("update", int'(update), int'(e_upd));
        check("hsync", int'(hsync), int'(e_hs));
        check("vsync", int'(vsync), int'(e_vs));
        check("video", int'(video), int'(e_vid));
        if (!hsync || !vsync) check("video_blank", int'(video), 0);
        if (update) upd_cnt++;
        if (video) vid_cnt++;
        if (!hsync) hs_cnt++;
        if (!vsync) vs_cnt++;
        drive_pixel();
    endtask

    task automatic release_reset();
        @(posedge clck);
        #1;
        check_reset_values("rst_hold");
        rst = 1'b0;
        n = 0;
        drive_pixel();
    endtask

    initial begin
        rst = 1'b1;
        pixel = 1'b0;
        mode = 0;
        n = 0;
        #1;
        check_reset_values("por");
        release_reset();

        // Random pixel stream across more than one frame.
        step();
        check("first_edge_x", int'(vgax), 1);
        check("first_edge_y", int'(vgay), 0);
        for (int i = 0; i < FRAME + 50; i++) step();

        // Asynchronous reset mid-line.
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            found = (px(n) == TX) && (py(n) == TY);
        end
        check("reach_mid", int'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");

        // Constant pixel=1 over three frames.
        mode = 1;
        release_reset();
        step();
        check("restart_x", int'(vgax), 1);
        check("restart_y", int'(vgay), 0);
        upd_cnt = 0; vid_cnt = 0; hs_cnt = 0; vs_cnt = 0; last_upd = -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (update) begin
                if (last_upd < 0) check("first_upd_n", n, VV * HT);
                else check("upd_spacing", n - last_upd, FRAME);
                last_upd = n;
            end
        end
        check("update_count", upd_cnt, 3);
        check("video_count", vid_cnt, 3 * HV * VV);
        check("hsync_low_count", hs_cnt, 3 * VT * HS);
        check("vsync_low_count", vs_cnt, 3 * VS * HT);

        // Consumer lighting a single coordinate.
        mode = 2;
        step();
        step();
        vid_cnt = 0;
        for (int i = 0; i < FRAME; i++) step();
        check("single_pixel_count", vid_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
